node_fanin_arbiter: RTL and testbench

Fan-in counterpart to the node tree's fan-out instantiation: merges beat streams from up to `NUM_CHILD` child instances into one upstream stream toward the parent node. Each child presents valid/ready beats with a `last` marker. The block arbitrates round-robin per packet, locks the grant for multi-beat packets, and tags each output beat with its source index. The output stage is registered so that node-tree levels can be cascaded without long combinational paths.

---
 rtl/node_tree_pkg.sv | 15 +
 rtl/node_fanin_arbiter_rr_pick.sv | 38 +++
 rtl/node_fanin_arbiter.sv | 131 +++++++++++++
 tb/tb_node_fanin_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_tree_pkg.sv
// Shared types and helpers for the node-tree fan-out / fan-in levels.
package node_tree_pkg;

    // Arbiter phase: free arbitration between packets, or locked to one child mid-packet.
    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of a child index; never narrower than one bit so a 1-child level still has a field.
    function automatic int child_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/node_fanin_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first set request at or after `start`,
// wrapping modulo N (N need not be a power of two). Purely combinational.
module rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW-1:0] cand [N];
    logic [N-1:0]  hit;

    // Candidate index for each search offset, wrapped back into 0..N-1.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum       = {1'b0, start} + (IW+1)'(gi);
        assign cand[gi]  = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    // Lowest search offset with a request wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/node_fanin_arbiter.sv
// Fan-in arbiter: merges child beat streams into one registered upstream stream,
// round-robin per packet with the grant locked for the length of a packet.
module node_fanin_arbiter
    import node_tree_pkg::*;
#(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CHILD-1:0]          child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0]   child_data,
    input  logic [NUM_CHILD-1:0]          child_last,
    output logic [NUM_CHILD-1:0]          child_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic [$clog2(NUM_CHILD)-1:0]  out_src,
    input  logic                          out_ready
);

    localparam int IW = child_idx_w(NUM_CHILD);

    arb_state_t    state_reg, state_next;
    logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0] lock_reg, lock_next;

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_last_reg;
    logic [IW-1:0]     out_src_reg;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] grant;
    logic          grant_en;
    logic          slot_free;
    logic          accept;
    logic [DATA_W-1:0] acc_data;
    logic          acc_last;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NUM_CHILD - 1)) ? '0 : v + 1'b1;
    endfunction

    rr_pick #(
        .N  (NUM_CHILD),
        .IW (IW)
    ) u_pick (
        .req   (child_valid),
        .start (rr_ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Reset kills the visible output immediately so an abandoned partial packet never leaks upstream.
    assign out_valid = out_valid_reg && !rst;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_src   = out_src_reg;

    assign slot_free = !out_valid || out_ready;
    // In BURST the locked child is offered the slot even while it has paused its valid.
    assign grant     = (state_reg == BURST) ? lock_reg : pick_idx;
    assign grant_en  = (state_reg == BURST) || pick_found;

    for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_ready
        assign child_ready[gi] = grant_en && slot_free && !rst && (grant == IW'(gi));
    end

    assign accept   = |(child_valid & child_ready);
    assign acc_data = child_data[grant*DATA_W +: DATA_W];
    assign acc_last = child_last[grant];

    // Arbitration state, round-robin pointer and packet lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ARB;
            rr_ptr_reg <= '0;
            lock_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            lock_reg   <= lock_next;
        end
    end

    // Packet boundaries move the pointer past the served child; a non-last first beat locks it.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        lock_next   = lock_reg;
        if (accept) begin
            case (state_reg)
                ARB: begin
                    if (acc_last) begin
                        rr_ptr_next = wrap_inc(grant);
                    end else begin
                        state_next = BURST;
                        lock_next  = grant;
                    end
                end
                BURST: begin
                    if (acc_last) begin
                        state_next  = ARB;
                        rr_ptr_next = wrap_inc(lock_reg);
                    end
                end
                default: state_next = ARB;
            endcase
        end
    end

    // Output slot: load on accept, empty when drained, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_src_reg   <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= acc_data;
            out_last_reg  <= acc_last;
            out_src_reg   <= grant;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_node_fanin_arbiter.sv
// Bench for node_fanin_arbiter: per-child beat sources, hand-written expected
// output sequences in a scoreboard queue, and a monitor that compares each upstream transfer.
module tb_node_fanin_arbiter;

    localparam int NC = 5;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     child_valid = '0;
    logic [NC*DW-1:0]  child_data  = '0;
    logic [NC-1:0]     child_last  = '0;
    logic [NC-1:0]     child_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [2:0]        out_src;
    logic              out_ready = 1'b1;

    node_fanin_arbiter #(.NUM_CHILD(NC), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_last  (child_last),
        .child_ready (child_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_src     (out_src),
        .out_ready   (out_ready)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Child beat sources: {last, data}
    logic [16:0]   cmem [NC][16];
    int            head [NC];
    int            tail [NC];
    logic [NC-1:0] fire = '0;

    // Expected upstream beats: {src[2:0], last, data[15:0]}
    logic [19:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic add_beat(input int ch, input logic [15:0] d, input logic l);
        cmem[ch][tail[ch]] = {l, d};
        tail[ch]++;
    endtask

    task automatic expect_beat(input logic [2:0] s, input logic [15:0] d, input logic l);
        exp_q.push_back({s, l, d});
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NC; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    // Source driver: retire fired beats just after the edge, then present the next head beat.
    initial begin
        clear_sources();
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (fire[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    child_valid[i]            = 1'b1;
                    child_data[i*DW +: DW]    = cmem[i][head[i]][15:0];
                    child_last[i]             = cmem[i][head[i]][16];
                end else begin
                    child_valid[i]            = 1'b0;
                    child_data[i*DW +: DW]    = '0;
                    child_last[i]             = 1'b0;
                end
            end
        end
    end

    // Monitor: on every upstream transfer pop and compare one expected beat.
    initial forever begin
        @(negedge clk);
        fire = child_valid & child_ready;
        if (out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got src=%0d data=0x%0h last=%0b want none",
                         out_src, out_data, out_last);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({out_src, out_last, out_data} !== e) begin
                    n_err++;
                    $display("FAIL beat: got src=%0d last=%0b data=0x%0h want src=%0d last=%0b data=0x%0h",
                             out_src, out_last, out_data, e[19:17], e[16], e[15:0]);
                end else begin
                    $display("ok   beat: src=%0d last=%0b data=0x%0h", out_src, out_last, out_data);
                end
            end
        end
    end

    task automatic sample();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        clear_sources();
        repeat (2) sample();
        rst = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        bit ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            sample();
            if (out_valid) ok = 1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no out_valid want out_valid within 50 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            sample();
            done = (exp_q.size() == 0);
            for (int i = 0; i < NC; i++) if (head[i] != tail[i]) done = 0;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d beats pending want 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            check({name, "_idle_after"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int rdy0_cnt;

        // Reset state
        repeat (2) sample();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ready",     32'(child_ready), 32'd0);
        check("rst_out_fields", {12'd0, out_src, out_last, out_data}, 32'd0);
        rst = 1'b0;

        // Single beat from child 3
        add_beat(3, 16'h00A5, 1'b1);
        expect_beat(3'd3, 16'h00A5, 1'b1);
        drain("single");

        // Wrap: pointer now 4, only children 1 and 4 valid
        add_beat(1, 16'h0111, 1'b1);
        add_beat(4, 16'h0444, 1'b1);
        expect_beat(3'd4, 16'h0444, 1'b1);
        expect_beat(3'd1, 16'h0111, 1'b1);
        drain("wrap");

        // Fairness: all children valid with single-beat packets
        do_reset();
        for (int i = 0; i < NC; i++) add_beat(i, 16'(16'h0100 * i), 1'b1);
        add_beat(0, 16'h0001, 1'b1);
        add_beat(1, 16'h0101, 1'b1);
        expect_beat(3'd0, 16'h0000, 1'b1);
        expect_beat(3'd1, 16'h0100, 1'b1);
        expect_beat(3'd2, 16'h0200, 1'b1);
        expect_beat(3'd3, 16'h0300, 1'b1);
        expect_beat(3'd4, 16'h0400, 1'b1);
        expect_beat(3'd0, 16'h0001, 1'b1);
        expect_beat(3'd1, 16'h0101, 1'b1);
        wait_out_valid("fair");
        for (int k = 1; k < 7; k++) begin
            sample();
            check($sformatf("fair_no_bubble_%0d", k), 32'(out_valid), 32'd1);
        end
        drain("fair");

        // Burst lock: move pointer to 2, then child 2 burst races child 0
        do_reset();
        add_beat(1, 16'h1111, 1'b1);
        expect_beat(3'd1, 16'h1111, 1'b1);
        drain("burst_pre");
        add_beat(2, 16'h2001, 1'b0);
        add_beat(2, 16'h2002, 1'b0);
        add_beat(2, 16'h2003, 1'b1);
        add_beat(0, 16'h0A0A, 1'b1);
        expect_beat(3'd2, 16'h2001, 1'b0);
        expect_beat(3'd2, 16'h2002, 1'b0);
        expect_beat(3'd2, 16'h2003, 1'b1);
        expect_beat(3'd0, 16'h0A0A, 1'b1);
        rdy0_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            sample();
            if (child_ready[0]) rdy0_cnt++;
        end
        check("burst_ready0_cycles", 32'(rdy0_cnt), 32'd1);
        drain("burst");

        // Backpressure: hold 0x1234 for 4 cycles
        do_reset();
        add_beat(0, 16'h1234, 1'b1);
        add_beat(1, 16'h5678, 1'b1);
        expect_beat(3'd0, 16'h1234, 1'b1);
        expect_beat(3'd1, 16'h5678, 1'b1);
        wait_out_valid("bp");
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            check($sformatf("bp_hold_%0d", c),
                  {7'd0, out_valid, 4'd0, out_src, out_last, out_data}, {7'd0, 1'b1, 4'd0, 3'd0, 1'b1, 16'h1234});
            check($sformatf("bp_ready_%0d", c), 32'(child_ready), 32'd0);
        end
        out_ready = 1'b1;
        sample();
        check("bp_next_beat", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h5678});
        drain("bp");

        // Reset mid-burst from child 1
        do_reset();
        add_beat(1, 16'h3001, 1'b0);
        add_beat(1, 16'h3002, 1'b0);
        add_beat(1, 16'h3003, 1'b1);
        expect_beat(3'd1, 16'h3001, 1'b0);
        wait_out_valid("mid");
        sample();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(child_ready), 32'd0);
        clear_sources();
        add_beat(3, 16'h3C3C, 1'b1);
        add_beat(0, 16'h0C0C, 1'b1);
        expect_beat(3'd0, 16'h0C0C, 1'b1);
        expect_beat(3'd3, 16'h3C3C, 1'b1);
        sample();
        check("mid_rst_hold_ready", 32'(child_ready), 32'd0);
        sample();
        rst = 1'b0;
        drain("mid_after");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
